// File: rtl/child_merge_pkg.sv
// Shared types and helpers for the child stream merger.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package child_merge_pkg;

    typedef enum logic {ARB, HOLD} merge_state_e;

    // Index width for n sources, never narrower than one bit.
    function automatic int src_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/child_stream_merger_rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping modulo N.
// Latency: purely combinational.
// Backpressure: none; the caller gates the grant with its own load enable.
module rr_pick #(
    parameter int N  = 5,
    parameter int PW = 3
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [PW-1:0] gnt_idx,
    output logic          gnt_valid
);

    logic [PW:0] idx;

    // Scan farthest-first so the candidate nearest ptr is the last writer and wins.
    always_comb begin
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        idx       = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = {1'b0, ptr} + (PW + 1)'(k);
            if (idx >= (PW + 1)'(N)) begin
                idx = idx - (PW + 1)'(N);
            end
            if (req[idx[PW-1:0]]) begin
                gnt_idx   = idx[PW-1:0];
                gnt_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/child_stream_merger.sv
// Merges N_CHILD child streams into one, round-robin with packet lock, tagged with source index.
// Latency: one register stage; full rate when out_ready stays high.
// Backpressure: out register holds while out_valid && !out_ready, and no child is granted meanwhile.
module child_stream_merger
    import child_merge_pkg::*;
#(
    parameter int  N_CHILD = 5,
    parameter int  DATA_W  = 32,
    parameter int  CNT_W   = 16,
    localparam int SRC_W   = src_w(N_CHILD)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_CHILD-1:0]          in_valid,
    input  logic [N_CHILD-1:0]          in_last,
    input  logic [N_CHILD*DATA_W-1:0]   in_data,
    output logic [N_CHILD-1:0]          in_ready,
    output logic                        out_valid,
    output logic                        out_last,
    output logic [SRC_W-1:0]            out_src,
    output logic [DATA_W-1:0]           out_data,
    input  logic                        out_ready,
    output logic [CNT_W-1:0]            beat_cnt
);

    merge_state_e       state;
    logic [SRC_W-1:0]   rr_ptr;
    logic [SRC_W-1:0]   lock_src;
    logic [SRC_W-1:0]   pick_idx;
    logic               pick_vld;
    logic [SRC_W-1:0]   grant;
    logic               grant_valid;
    logic               load_en;
    logic               xfer;
    logic               sel_last;
    logic [DATA_W-1:0]  sel_data;
    logic [SRC_W-1:0]   nxt_ptr;

    rr_pick #(.N(N_CHILD), .PW(SRC_W)) u_pick (
        .req       (in_valid),
        .ptr       (rr_ptr),
        .gnt_idx   (pick_idx),
        .gnt_valid (pick_vld)
    );

    // A locked packet bypasses the picker: idle gaps from lock_src keep everyone else out.
    always_comb begin
        grant       = pick_idx;
        grant_valid = pick_vld;
        if (state == HOLD) begin
            grant       = lock_src;
            grant_valid = in_valid[lock_src];
        end
    end

    assign load_en  = !out_valid || out_ready;
    assign xfer     = load_en && grant_valid && !rst;
    assign sel_last = in_last[grant];
    assign sel_data = in_data[int'(grant)*DATA_W +: DATA_W];
    assign nxt_ptr  = (grant == SRC_W'(N_CHILD - 1)) ? '0 : grant + 1'b1;

    always_comb begin
        in_ready = '0;
        if (xfer) begin
            in_ready[grant] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ARB;
            rr_ptr    <= '0;
            lock_src  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_src   <= '0;
            out_data  <= '0;
            beat_cnt  <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_last  <= sel_last;
            out_src   <= grant;
            out_data  <= sel_data;
            beat_cnt  <= beat_cnt + CNT_W'(1);
            if (sel_last) begin
                rr_ptr <= nxt_ptr;
                state  <= ARB;
            end else begin
                lock_src <= grant;
                state    <= HOLD;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    a_ready_onehot0: assert property (@(posedge clk) $onehot0(in_ready));

    a_out_stable: assert property (@(posedge clk) disable iff (rst)
        out_valid && !out_ready |=> out_valid && $stable(out_data) && $stable(out_src) && $stable(out_last));

    a_hold_only_lock: assert property (@(posedge clk) disable iff (rst)
        (state == HOLD) && (|in_ready) |-> in_ready[lock_src]);

endmodule

// File: tb/tb_child_stream_merger.sv
// Directed bench for child_stream_merger with a per-cycle reference model and literal spot checks.
// Inputs change 2 time units after the rising edge; the model compares on the falling edge.
module tb_child_stream_merger;

    localparam int N  = 5;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    in_valid;
    logic [N-1:0]    in_last;
    logic [N*DW-1:0] in_data;
    logic [N-1:0]    in_ready;
    logic            out_valid;
    logic            out_last;
    logic [2:0]      out_src;
    logic [DW-1:0]   out_data;
    logic            out_ready;
    logic [15:0]     beat_cnt;

    int tests = 0;
    int fails = 0;

    child_stream_merger #(.N_CHILD(N), .DATA_W(DW), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_src   (out_src),
        .out_data  (out_data),
        .out_ready (out_ready),
        .beat_cnt  (beat_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what the output register must hold, and who holds the packet lock.
    logic        m_valid;
    logic        m_last;
    int          m_src;
    logic [31:0] m_data;
    logic [15:0] m_cnt;
    int          m_lock;
    int          m_turn;
    int          cand;
    int          c;
    logic [N-1:0] m_rdy;

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_data", out_data, 0);
            chk("rst_in_ready", in_ready, 0);
            chk("rst_beat_cnt", beat_cnt, 0);
            m_valid = 1'b0; m_last = 1'b0; m_src = 0; m_data = '0; m_cnt = '0;
            m_lock = -1; m_turn = 0;
        end else begin
            chk("out_valid", out_valid, m_valid);
            chk("out_last", out_last, m_last);
            chk("out_src", out_src, m_src);
            chk("out_data", out_data, m_data);
            chk("beat_cnt", beat_cnt, m_cnt);
            cand = -1;
            if (!m_valid || out_ready) begin
                if (m_lock >= 0) begin
                    if (in_valid[m_lock]) cand = m_lock;
                end else begin
                    for (int k = 0; k < N; k++) begin
                        c = (m_turn + k) % N;
                        if (cand < 0 && in_valid[c]) cand = c;
                    end
                end
            end
            m_rdy = '0;
            if (cand >= 0) m_rdy[cand] = 1'b1;
            chk("in_ready", in_ready, m_rdy);
            if (cand >= 0) begin
                m_valid = 1'b1;
                m_src   = cand;
                m_last  = in_last[cand];
                m_data  = in_data[cand*DW +: DW];
                m_cnt   = m_cnt + 16'd1;
                if (in_last[cand]) begin
                    m_lock = -1;
                    m_turn = (cand + 1) % N;
                end else begin
                    m_lock = cand;
                end
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_child(input int i, input logic v, input logic l, input logic [31:0] d);
        in_valid[i] = v;
        in_last[i]  = l;
        in_data[i*DW +: DW] = d;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = '1;
        in_last   = '1;
        in_data   = '1;
        out_ready = 1'b1;
        #1;
        chk("t0_out_valid", out_valid, 0);
        chk("t0_out_src", out_src, 0);
        chk("t0_in_ready", in_ready, 0);
        chk("t0_beat_cnt", beat_cnt, 0);
        step(); step();
        in_valid = '0; in_last = '0; in_data = '0;
        rst = 1'b0;
        step();

        // Single source: two one-beat packets from child 2 on consecutive cycles.
        set_child(2, 1'b1, 1'b1, 32'hA5);
        step();
        chk("single_src0", out_src, 2);
        chk("single_data0", out_data, 32'hA5);
        set_child(2, 1'b1, 1'b1, 32'h5A);
        step();
        chk("single_data1", out_data, 32'h5A);
        chk("single_valid1", out_valid, 1);
        set_child(2, 1'b0, 1'b0, 32'h0);
        step();
        chk("single_drain", out_valid, 0);
        chk("single_cnt", beat_cnt, 2);

        // Fairness from a fresh arbiter: 0,1,2,3,4,0,... at one beat per cycle.
        rst = 1'b1; step(); rst = 1'b0;
        for (int i = 0; i < N; i++) set_child(i, 1'b1, 1'b1, 32'h100 + i);
        for (int b = 0; b < 10; b++) begin
            step();
            chk("fair_src", out_src, b % N);
            chk("fair_valid", out_valid, 1);
        end
        in_valid = '0;

        // Packet lock: child 1 three beats with a 2-cycle gap, child 3 always valid.
        set_child(3, 1'b1, 1'b1, 32'h33);
        set_child(1, 1'b1, 1'b0, 32'h11);
        step();
        chk("lock_b1", out_src, 1);
        set_child(1, 1'b0, 1'b0, 32'h0);
        #1;
        chk("lock_gap_rdy", in_ready, 0);
        step();
        chk("lock_gap1", out_valid, 0);
        step();
        chk("lock_gap2", out_valid, 0);
        set_child(1, 1'b1, 1'b0, 32'h12);
        step();
        chk("lock_b2", out_src, 1);
        set_child(1, 1'b1, 1'b1, 32'h13);
        step();
        chk("lock_b3", out_src, 1);
        chk("lock_b3_last", out_last, 1);
        set_child(1, 1'b0, 1'b0, 32'h0);
        step();
        chk("lock_then3", out_src, 3);
        chk("lock_then3_data", out_data, 32'h33);
        set_child(3, 1'b0, 1'b0, 32'h0);
        step();

        // Backpressure: output held for 4 cycles, then drain and refill together.
        out_ready = 1'b0;
        set_child(0, 1'b1, 1'b1, 32'h11);
        step();
        chk("bp_first", out_data, 32'h11);
        set_child(0, 1'b1, 1'b1, 32'h22);
        for (int s = 0; s < 4; s++) begin
            step();
            chk("bp_hold_data", out_data, 32'h11);
            chk("bp_hold_src", out_src, 0);
            chk("bp_hold_rdy", in_ready, 0);
        end
        out_ready = 1'b1;
        step();
        chk("bp_next", out_data, 32'h22);
        set_child(0, 1'b0, 1'b0, 32'h0);
        step();
        chk("bp_cnt", beat_cnt, 16);

        // Counter wrap: bring the count to all-ones, then one more beat.
        set_child(4, 1'b1, 1'b1, 32'h44);
        repeat (65535 - 16) step();
        set_child(4, 1'b0, 1'b0, 32'h0);
        step();
        chk("cnt_full", beat_cnt, 16'hFFFF);
        set_child(4, 1'b1, 1'b1, 32'h45);
        step();
        set_child(4, 1'b0, 1'b0, 32'h0);
        chk("cnt_wrap", beat_cnt, 0);
        step();

        // Reset in the middle of a locked packet from child 2.
        set_child(2, 1'b1, 1'b0, 32'h77);
        step();
        chk("mid_lock", out_src, 2);
        for (int i = 0; i < N; i++) set_child(i, 1'b1, (i != 2), 32'h200 + i);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_rdy", in_ready, 0);
        step(); step();
        rst = 1'b0;
        step();
        chk("post_rst_src", out_src, 0);
        chk("post_rst_data", out_data, 32'h200);
        in_valid = '0;
        step(); step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
